// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents:
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
//   clog2       : ceiling log2, minimum 1, used to size index and beat counters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Sizes registers, so a width of 0 is never returned.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester after last_i, wrapping, last_i itself checked last.
// Latency: purely combinational.
// Backpressure: none; it only looks at the request vector.
//
// Ports:
//   req_i    [N-1:0]  request vector
//   last_i   [IW-1:0] index of the previous winner
//   onehot_o [N-1:0]  one-hot winner (all-zero when no request)
//   idx_o    [IW-1:0] winner index (0 when no request)
//   any_o             at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int best_i;
  int best_d;
  int d;

  // Each requester's distance past last_i, modulo N. The smallest distance wins.
  // last_i itself is at distance N-1, so it is checked last.
  always_comb begin
    best_i = 0;
    best_d = N;
    d      = 0;
    any_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(last_i) - 1;
      if (d < 0) d = d + N;
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
        any_o  = 1'b1;
      end
    end
    idx_o    = IW'(best_i);
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = any_o && (best_i == i);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that gives one producer at a time the write port of a single-clock FIFO.
// Latency: a request made in IDLE is granted the next cycle, and that cycle writes if the FIFO is not full.
// Backpressure: fifo_full_i stalls the granted producer and holds the grant and beat count; a stall is not a beat.
//
// Optional feature macro: FIFO_ARB_BURST_EN. When it is defined, a grant lasts until req_last_i
// or until MAX_BURST beats. When it is undefined, every write ends the grant, which gives
// per-word round-robin.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid_i/data_i/last_i   per-producer stream inputs (data packed i*DATA_WIDTH +: DATA_WIDTH)
//   req_ready_o                 accept strobe, only for the granted producer
//   fifo_full_i                 FIFO full flag
//   fifo_wr_en_o/wr_data_o      FIFO write port (combinational)
//   grant_o, busy_o             registered one-hot grant, and state==GRANT
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int IW = clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               g_vld;
  logic               xfer;
  logic               burst_end;
  logic               release_g;

  // last_q always holds the index of the current grant. The same picker therefore
  // serves the initial grant from IDLE and a re-grant on release.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i    (req_valid_i),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // grant_q is all-zero outside GRANT, so every term below is zero when idle.
  assign g_vld        = |(req_valid_i & grant_q);
  assign xfer         = g_vld & ~fifo_full_i;
  assign fifo_wr_en_o = xfer;
  assign req_ready_o  = xfer ? grant_q : '0;

  always_comb begin
    fifo_wr_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_wr_data_o = fifo_wr_data_o | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts beats already written. The beat that makes MAX_BURST ends the burst.
  assign burst_end = xfer & ((|(req_last_i & grant_q)) | (cnt_q == CW'(MAX_BURST - 1)));
`else
  localparam int unused_max_burst = MAX_BURST;
  logic unused_last;

  assign unused_last = ^req_last_i;
  assign burst_end   = xfer;
`endif

  // A stall under full leaves g_vld high, so it never causes a release.
  assign release_g = (state_q == GRANT) & (burst_end | ~g_vld);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_oh;
          last_d  = pick_idx;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (xfer) cnt_d = cnt_q + 1'b1;
`endif
        if (release_g) begin
          if (pick_any) begin
            grant_d = pick_oh;
            last_d  = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`ifdef FIFO_ARB_BURST_EN
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == GRANT);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter sharing one single-clock FIFO write port between NUM_REQ producers. Each producer presents a valid/ready stream; the arbiter grants one producer at a time, holds the grant for a bounded burst, and drives the FIFO's write enable and data while honouring its full flag. It sits directly in front of the FIFO's write side, so every write port of a shared store buffer has exactly one owner per cycle.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (≥2)
- DATA_WIDTH, 8, data width per producer and FIFO word width (≥1)
- MAX_BURST, 4, maximum beats per grant (≥1; only meaningful with FIFO_ARB_BURST_EN)

Ports (one clock, `clk`; synchronous active-high reset, `rst`):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  producer i has a word
- req_data_i  in  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  in  NUM_REQ  producer i's current word ends its burst
- req_ready_o  out  NUM_REQ  producer i's word is accepted this cycle
- fifo_full_i  in  1  FIFO full flag
- fifo_wr_en_o  out  1  FIFO write enable
- fifo_wr_data_o  out  DATA_WIDTH  FIFO write data
- grant_o  out  NUM_REQ  one-hot registered grant (all-zero when idle)
- busy_o  out  1  state is GRANT

## Operation
- States: IDLE, GRANT. Registers: state_q, grant_q (one-hot), last_q (index of last granted producer), cnt_q (beats in current burst, width clog2(MAX_BURST+1)).
- Pick: first i with req_valid_i[i] scanning last_q+1, last_q+2, … modulo NUM_REQ, last_q itself checked last.
- IDLE: if any req_valid_i, grant_q <= pick, last_q <= pick index, cnt_q <= 0, go GRANT; else stay.
- GRANT: fifo_wr_en_o = req_valid_i[g] & !fifo_full_i; req_ready_o[g] = fifo_wr_en_o; other ready bits 0; fifo_wr_data_o = data of g (grant_q mux; all-zero when idle).
- Transfer (fifo_wr_en_o=1): cnt_q += 1. Burst end if req_last_i[g] or cnt_q == MAX_BURST-1.
- Grant release: on burst end, or when req_valid_i[g]=0 (no transfer). On release: if any req_valid_i (pick computed with current g as last_q), re-grant directly (GRANT→GRANT, cnt_q <= 0, no idle cycle); else go IDLE, grant_q <= 0.
- Full: fifo_full_i=1 blocks the transfer; grant, cnt_q held; stall does not count as a beat and does not release the grant.
- Single active producer re-wins after its own burst end (self checked last).
- fifo_wr_en_o never asserts while fifo_full_i=1 and never for an ungranted producer.

## Timing
- Reset: state IDLE, grant_q 0, last_q NUM_REQ-1 (producer 0 highest priority first), cnt_q 0; outputs grant_o 0, busy_o 0, req_ready_o 0, fifo_wr_en_o 0, fifo_wr_data_o 0.
- rst mid-burst: next cycle all of the above; in-flight word not written unless fifo_wr_en_o was high in the rst cycle (FIFO handles its own reset).
- Latency: valid in IDLE at cycle n → grant_o at n+1 → first write at n+1 if not full.
- fifo_wr_en_o/req_ready_o/fifo_wr_data_o combinational from grant_q, req_valid_i, fifo_full_i; grant_o, busy_o registered.
- Full deassert at cycle n → write at cycle n.

## Configuration
- FIFO_ARB_BURST_EN defined: bursts as above, bounded by req_last_i and MAX_BURST.
- Undefined: every transfer is a burst end (MAX_BURST treated as 1, req_last_i ignored, cnt_q removed); strict per-word round-robin.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, GRANT), clog2 function for cnt_q/index widths.
- Sub-module rr_pick: combinational round-robin priority encoder (req vector, last index → one-hot and index, any flag).

## Test plan
- Reset, req_valid_i=4'b0000 → grant_o 0, fifo_wr_en_o 0, busy_o 0 for 10 cycles.
- req_valid_i=4'b1111 continuously, last never set, BURST_EN, MAX_BURST=4 → grants 0,1,2,3,0 each 4 beats, no idle cycles between.
- Without macro, same stimulus → grant rotates 0,1,2,3 every write.
- Producer 2 only, fifo_full_i high 5 cycles mid-burst → no writes, grant held, burst completes 4 beats after full drops.
- Producer 1 sends 2 words with req_last_i on word 2 while producer 3 valid → grant moves to 3 after 2 beats.
- rst asserted during producer 0 burst at beat 2 → next cycle grant_o 0, busy_o 0, then producer 0 re-granted first.
